// File: rtl/cyclic_coder_sequencer.sv
// rtl/cyclic_coder_sequencer.sv - message-to-codeword sequencer driving an external serial cyclic coder
module cyclic_coder_sequencer #(
    parameter int K = 7,
    parameter int N = 15
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         msg_valid,
    input  logic [K-1:0] msg_data,
    output logic         msg_ready,
    output logic         coder_reset,
    output logic         coder_enable,
    output logic         coder_in,
    input  logic         coder_out,
    output logic         cw_valid,
    output logic [N-1:0] cw_data,
    input  logic         cw_ready,
    output logic         busy
);

    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST_SHIFT = CW'(N - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t          state_q;
    logic [CW-1:0]   cnt_q;
    logic [K-1:0]    msg_q;
    logic [N-1:0]    cw_q;
    logic            msg_ready_q;
    logic            coder_reset_q;
    logic            coder_enable_q;
    logic            coder_in_q;
    logic            cw_valid_q;
    logic            busy_q;

    // Sequencer FSM; every output register is loaded with its value for the state being entered.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q        <= IDLE;
            cnt_q          <= '0;
            msg_q          <= '0;
            cw_q           <= '0;
            msg_ready_q    <= 1'b1;
            coder_reset_q  <= 1'b1;
            coder_enable_q <= 1'b0;
            coder_in_q     <= 1'b0;
            cw_valid_q     <= 1'b0;
            busy_q         <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    coder_reset_q <= 1'b0;
                    if (msg_valid) begin
                        msg_q         <= msg_data;
                        state_q       <= CLEAR;
                        msg_ready_q   <= 1'b0;
                        busy_q        <= 1'b1;
                        coder_reset_q <= 1'b1;
                    end
                end
                CLEAR: begin
                    // Present message bit 0 for shift cycle 0; later bits follow as the register drains.
                    state_q        <= SHIFT;
                    cnt_q          <= '0;
                    coder_reset_q  <= 1'b0;
                    coder_enable_q <= 1'b1;
                    coder_in_q     <= msg_q[0];
                    msg_q          <= msg_q >> 1;
                end
                SHIFT: begin
                    cw_q[cnt_q] <= coder_out;
                    if (cnt_q == LAST_SHIFT) begin
                        state_q        <= DONE;
                        coder_enable_q <= 1'b0;
                        coder_in_q     <= 1'b0;
                        cw_valid_q     <= 1'b1;
                    end else begin
                        // Zeros shifted into the top give the flush bits after cycle K-1.
                        cnt_q      <= cnt_q + 1'b1;
                        coder_in_q <= msg_q[0];
                        msg_q      <= msg_q >> 1;
                    end
                end
                DONE: begin
                    if (cw_ready) begin
                        state_q     <= IDLE;
                        cw_valid_q  <= 1'b0;
                        msg_ready_q <= 1'b1;
                        busy_q      <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Reset low overrides the registered outputs immediately so the coder is held clear.
    always_comb begin
        msg_ready    = msg_ready_q & reset;
        busy         = busy_q & reset;
        coder_enable = coder_enable_q & reset;
        coder_in     = coder_in_q & reset;
        coder_reset  = coder_reset_q | ~reset;
        cw_valid     = cw_valid_q & reset;
        cw_data      = cw_q;
    end

endmodule

// File: tb/tb_cyclic_coder_sequencer.sv
// tb/tb_cyclic_coder_sequencer.sv - self-checking bench with a [15,7] serial coder model
module tb_cyclic_coder_sequencer;

    localparam int K = 7;
    localparam int N = 15;
    localparam logic [N-1:0] G = 15'h01D1;

    logic         clock;
    logic         reset;
    logic         msg_valid;
    logic [K-1:0] msg_data;
    logic         msg_ready;
    logic         coder_reset;
    logic         coder_enable;
    logic         coder_in;
    logic         coder_out;
    logic         cw_valid;
    logic [N-1:0] cw_data;
    logic         cw_ready;
    logic         busy;

    int errors = 0;
    int checks = 0;

    cyclic_coder_sequencer #(.K(K), .N(N)) dut (
        .clock        (clock),
        .reset        (reset),
        .msg_valid    (msg_valid),
        .msg_data     (msg_data),
        .msg_ready    (msg_ready),
        .coder_reset  (coder_reset),
        .coder_enable (coder_enable),
        .coder_in     (coder_in),
        .coder_out    (coder_out),
        .cw_valid     (cw_valid),
        .cw_data      (cw_data),
        .cw_ready     (cw_ready),
        .busy         (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Serial nonsystematic coder: output = sum over taps g_j * in(i-j).
    logic [7:0] hist;
    assign coder_out = coder_in ^ (^(hist & 8'hE8));
    always @(posedge clock) begin
        if (coder_reset) hist <= '0;
        else if (coder_enable) hist <= {hist[6:0], coder_in};
    end

    // Reference: codeword polynomial is m(x) * g(x) over GF(2).
    function automatic logic [N-1:0] encode(input logic [K-1:0] m);
        logic [N-1:0] c;
        c = '0;
        for (int j = 0; j < K; j++)
            if (m[j]) c = c ^ (G << j);
        return c;
    endfunction

    task automatic accept(input logic [K-1:0] m, input string name);
        int k;
        k = 0;
        while (!msg_ready && k < 60) begin
            @(negedge clock);
            k++;
        end
        checks++;
        if (msg_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s_ready_timeout got=%b want=1", name, msg_ready);
        end
        msg_valid = 1'b1;
        msg_data  = m;
        @(posedge clock);
        @(negedge clock);
        msg_valid = 1'b0;
        msg_data  = K'($urandom);
    endtask

    task automatic test_reset();
        reset = 1'b0; msg_valid = 1'b1; msg_data = 7'h55; cw_ready = 1'b1;
        repeat (3) @(posedge clock);
        @(negedge clock);
        checks++;
        if ({msg_ready, busy, coder_enable, coder_reset, cw_valid} !== 5'b00010) begin
            errors++;
            $display("FAIL reset_ctrl got=%b want=00010", {msg_ready, busy, coder_enable, coder_reset, cw_valid});
        end
        checks++;
        if (cw_data !== '0) begin
            errors++;
            $display("FAIL reset_cw_data got=%h want=0000", cw_data);
        end
        msg_valid = 1'b0;
        reset = 1'b1;
        @(negedge clock);
        checks++;
        if ({msg_ready, busy} !== 2'b10) begin
            errors++;
            $display("FAIL reset_release got=%b want=10", {msg_ready, busy});
        end
        repeat (2) @(negedge clock);
    endtask

    task automatic run_one(input logic [K-1:0] m, input string name);
        int k, en_cnt, clr_cnt, in_err;
        logic [N-1:0] exp;
        exp = encode(m);
        accept(m, name);
        k = 1; en_cnt = 0; clr_cnt = 0; in_err = 0;
        while (!cw_valid && k < 40) begin
            if (coder_enable) begin
                // shift cycle i = k-2 must carry message bit i, then flush zeros
                if (coder_in !== ((k - 2 < K) ? m[k-2] : 1'b0)) in_err++;
                en_cnt++;
            end
            clr_cnt += int'(coder_reset);
            @(negedge clock);
            k++;
        end
        checks++;
        if (k != N + 2) begin errors++; $display("FAIL %s_latency got=%0d want=%0d", name, k, N + 2); end
        checks++;
        if (cw_data !== exp) begin errors++; $display("FAIL %s_cw_data got=%h want=%h", name, cw_data, exp); end
        checks++;
        if (en_cnt != N || clr_cnt != 1 || in_err != 0) begin
            errors++;
            $display("FAIL %s_coder_ctrl enables=%0d resets=%0d in_errs=%0d want %0d/1/0", name, en_cnt, clr_cnt, in_err, N);
        end
        @(negedge clock);
        checks++;
        if ({cw_valid, msg_ready, busy} !== 3'b010 || cw_data !== exp) begin
            errors++;
            $display("FAIL %s_handshake got v/r/b=%b data=%h want 010 data=%h", name, {cw_valid, msg_ready, busy}, cw_data, exp);
        end
    endtask

    task automatic test_vectors();
        run_one(7'h01, "vec01");
        run_one(7'h03, "vec03");
        run_one(7'h00, "vec00");
    endtask

    task automatic test_random();
        for (int r = 0; r < 8; r++) run_one(K'($urandom), "rand");
    endtask

    task automatic test_hold();
        logic [K-1:0] m;
        logic [N-1:0] exp;
        int k, bad;
        m = K'($urandom) | 7'h40;
        exp = encode(m);
        cw_ready = 1'b0;
        accept(m, "hold");
        k = 0;
        while (!cw_valid && k < 40) begin @(negedge clock); k++; end
        bad = 0;
        for (int c = 0; c < 5; c++) begin
            if (cw_valid !== 1'b1 || cw_data !== exp || msg_ready !== 1'b0 || busy !== 1'b1) bad++;
            msg_valid = (c % 2 == 0);
            msg_data  = K'($urandom);
            @(negedge clock);
        end
        checks++;
        if (bad != 0) begin errors++; $display("FAIL hold_stable got=%0d bad cycles want=0", bad); end
        checks++;
        if (cw_data !== exp || cw_valid !== 1'b1) begin
            errors++;
            $display("FAIL hold_data got=%h v=%b want=%h v=1", cw_data, cw_valid, exp);
        end
        msg_valid = 1'b0;
        cw_ready  = 1'b1;
        @(negedge clock);
        bad = 0;
        for (int c = 0; c < 4; c++) begin
            if (cw_valid !== 1'b0 || busy !== 1'b0 || msg_ready !== 1'b1) bad++;
            @(negedge clock);
        end
        checks++;
        if (bad != 0) begin errors++; $display("FAIL hold_not_consumed got=%0d bad cycles want=0", bad); end
    endtask

    task automatic test_back_to_back();
        logic [K-1:0] m;
        logic [N-1:0] exp;
        int acc[$];
        int cyc, pulses, cws, bad_cw;
        logic prev_rst;
        m = K'($urandom) | 7'h01;
        exp = encode(m);
        cw_ready = 1'b1;
        msg_valid = 1'b1;
        msg_data = m;
        cyc = 0; pulses = 0; cws = 0; bad_cw = 0; prev_rst = 1'b0;
        while (acc.size() < 4 && cyc < 120) begin
            if (acc.size() > 0) begin
                if (coder_reset && !prev_rst) pulses++;
                if (cw_valid) begin
                    cws++;
                    if (cw_data !== exp) bad_cw++;
                end
            end
            prev_rst = coder_reset;
            if (msg_ready && msg_valid) acc.push_back(cyc);
            @(negedge clock);
            cyc++;
        end
        msg_valid = 1'b0;
        checks++;
        if (acc.size() != 4) begin
            errors++;
            $display("FAIL b2b_accepts got=%0d want=4", acc.size());
        end else begin
            for (int i = 1; i < 4; i++) begin
                checks++;
                if (acc[i] - acc[i-1] != N + 3) begin
                    errors++;
                    $display("FAIL b2b_gap got=%0d want=%0d", acc[i] - acc[i-1], N + 3);
                end
            end
        end
        checks++;
        if (pulses != 3 || cws != 3 || bad_cw != 0) begin
            errors++;
            $display("FAIL b2b_pulses got clr=%0d cw=%0d bad=%0d want 3/3/0", pulses, cws, bad_cw);
        end
        cyc = 0;
        while (!msg_ready && cyc < 40) begin @(negedge clock); cyc++; end
    endtask

    task automatic test_abort();
        int bad;
        cw_ready = 1'b1;
        accept(7'h5A, "abort");
        // now at k=1 (CLEAR); SHIFT cycle 6 is k=8
        repeat (7) @(negedge clock);
        checks++;
        if (coder_enable !== 1'b1) begin errors++; $display("FAIL abort_in_shift got=%b want=1", coder_enable); end
        reset = 1'b0;
        @(posedge clock);
        @(negedge clock);
        checks++;
        if ({busy, cw_valid, coder_reset, coder_enable} !== 4'b0010 || cw_data !== '0) begin
            errors++;
            $display("FAIL abort_state got b/v/r/e=%b data=%h want 0010 data=0000", {busy, cw_valid, coder_reset, coder_enable}, cw_data);
        end
        reset = 1'b1;
        bad = 0;
        for (int c = 0; c < 25; c++) begin
            @(negedge clock);
            if (cw_valid !== 1'b0 || busy !== 1'b0 || coder_enable !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin errors++; $display("FAIL abort_no_replay got=%0d bad cycles want=0", bad); end
        checks++;
        if (msg_ready !== 1'b1) begin errors++; $display("FAIL abort_ready got=%b want=1", msg_ready); end
    endtask

    initial begin
        reset = 1'b0; msg_valid = 1'b0; msg_data = '0; cw_ready = 1'b1;
        @(negedge clock);
        test_reset();
        test_vectors();
        test_random();
        test_hold();
        test_back_to_back();
        test_abort();
        run_one(7'h01, "post_abort");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
